vend_payment_ctrl: RTL and testbench

VEND_PAYMENT_CTRL -- requirements
Module: vend_payment_ctrl

---
 rtl/vend_payment_ctrl_if.sv | 45 ++++
 rtl/vend_payment_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_vend_payment_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_payment_ctrl_if.sv
// Vending payment controller bus: configuration, coin/selection inputs,
// vend and change handshakes, and status outputs.
interface vend_payment_ctrl_if #(
  parameter int NUM_ITEMS = 8,
  parameter int PRICE_W   = 8,
  parameter int BAL_W     = 11,
  parameter int CRED_W    = 9,
  parameter int IDX_W     = 4
);
  logic [NUM_ITEMS*PRICE_W-1:0] price_table;
  logic [CRED_W-1:0]            cred_init;
  logic                         coin_valid;
  logic [1:0]                   coin_type;
  logic                         pay_mode;
  logic                         sel_valid;
  logic [IDX_W-1:0]             sel_index;
  logic                         cancel;
  logic                         vend_ack;
  logic                         chg_ack;
  logic                         vend_req;
  logic [IDX_W-1:0]             vend_idx;
  logic                         chg_valid;
  logic [1:0]                   chg_coin;
  logic [BAL_W-1:0]             balance;
  logic [CRED_W-1:0]            credit;
  logic                         busy;
  logic                         err_funds;
  logic                         err_index;
  logic                         coin_reject;
  logic                         cancel_done;

  modport master (
    output price_table, cred_init, coin_valid, coin_type, pay_mode,
           sel_valid, sel_index, cancel, vend_ack, chg_ack,
    input  vend_req, vend_idx, chg_valid, chg_coin, balance, credit,
           busy, err_funds, err_index, coin_reject, cancel_done
  );

  modport slave (
    input  price_table, cred_init, coin_valid, coin_type, pay_mode,
           sel_valid, sel_index, cancel, vend_ack, chg_ack,
    output vend_req, vend_idx, chg_valid, chg_coin, balance, credit,
           busy, err_funds, err_index, coin_reject, cancel_done
  );
endinterface

// File: rtl/vend_payment_ctrl.sv
// Vending payment controller: accepts coins, checks funds against a price
// list captured at reset, drives the vend handshake, and refunds the cash
// balance greedily (largest coin first) on cancel.
module vend_payment_ctrl #(
  parameter int NUM_ITEMS = 8,
  parameter int PRICE_W   = 8,
  parameter int BAL_W     = 11,
  parameter int CRED_W    = 9,
  parameter int IDX_W     = 4
) (
  input logic clk,
  input logic rst,
  vend_payment_ctrl_if.slave bus
);
  // Common arithmetic width wide enough for balance, credit and price plus carry.
  localparam int MW1 = (BAL_W > CRED_W) ? BAL_W : CRED_W;
  localparam int AW  = ((MW1 > PRICE_W) ? MW1 : PRICE_W) + 2;
  localparam logic [AW-1:0] BAL_MAX = {{(AW-BAL_W){1'b0}}, {BAL_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, CHECK, VEND, CHANGE} state_t;

  state_t                       state;
  logic [NUM_ITEMS*PRICE_W-1:0] priceReg;
  logic [IDX_W-1:0]             latIdx;
  logic                         latMode;
  logic [BAL_W-1:0]             balance;
  logic [CRED_W-1:0]            credit;
  logic                         vendReq, chgValid, busyR;
  logic [IDX_W-1:0]             vendIdx;
  logic [1:0]                   chgCoin;
  logic                         errFunds, errIndex, coinReject, cancelDone;

  // Coin code to cents.
  function automatic logic [AW-1:0] coinValue(input logic [1:0] code);
    case (code)
      2'd0:    coinValue = AW'(7'd5);
      2'd1:    coinValue = AW'(7'd10);
      2'd2:    coinValue = AW'(7'd25);
      2'd3:    coinValue = AW'(7'd100);
      default: coinValue = AW'(7'd0);
    endcase
  endfunction

  // Largest coin not exceeding the given amount.
  function automatic logic [1:0] greedyCoin(input logic [AW-1:0] amt);
    if (amt >= AW'(7'd100))     greedyCoin = 2'd3;
    else if (amt >= AW'(7'd25)) greedyCoin = 2'd2;
    else if (amt >= AW'(7'd10)) greedyCoin = 2'd1;
    else                        greedyCoin = 2'd0;
  endfunction

  // Index-addressable view of the captured price list; unused slots read zero.
  logic [PRICE_W-1:0] priceAt [(1<<IDX_W)];
  for (genvar gi = 0; gi < (1 << IDX_W); gi++) begin : g_price
    if (gi < NUM_ITEMS) begin : g_used
      assign priceAt[gi] = priceReg[gi*PRICE_W +: PRICE_W];
    end else begin : g_unused
      assign priceAt[gi] = {PRICE_W{1'b0}};
    end
  end

  logic [AW-1:0] balW, credW, priceW, coinW, sumW, balCoin, fundsW, chgRem;
  logic          coinOk, idxBad;

  // Coin acceptance, fund selection and refund remainder.
  always_comb begin
    balW   = AW'(balance);
    credW  = AW'(credit);
    priceW = AW'(priceAt[latIdx]);
    coinW  = coinValue(bus.coin_type);
    sumW   = balW + coinW;
    if (bus.coin_valid && (state != CHANGE) && (sumW <= BAL_MAX)) coinOk = 1'b1;
    else                                                          coinOk = 1'b0;
    if (coinOk) balCoin = sumW;
    else        balCoin = balW;
    if (latMode) fundsW = credW;
    else         fundsW = balW;
    chgRem = balW - coinValue(chgCoin);
    idxBad = ({{(32-IDX_W){1'b0}}, bus.sel_index} >= 32'(NUM_ITEMS));
  end

  // Payment FSM with registered handshake, balance and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      priceReg   <= bus.price_table;
      credit     <= bus.cred_init;
      balance    <= {BAL_W{1'b0}};
      latIdx     <= {IDX_W{1'b0}};
      latMode    <= 1'b0;
      vendReq    <= 1'b0;
      vendIdx    <= {IDX_W{1'b0}};
      chgValid   <= 1'b0;
      chgCoin    <= 2'd0;
      busyR      <= 1'b0;
      errFunds   <= 1'b0;
      errIndex   <= 1'b0;
      coinReject <= 1'b0;
      cancelDone <= 1'b0;
    end else begin
      errFunds   <= 1'b0;
      errIndex   <= 1'b0;
      cancelDone <= 1'b0;
      coinReject <= bus.coin_valid & ~coinOk;
      balance    <= BAL_W'(balCoin);
      case (state)
        IDLE: begin
          if (bus.cancel) begin
            if (balance != {BAL_W{1'b0}}) begin
              state    <= CHANGE;
              busyR    <= 1'b1;
              chgValid <= 1'b1;
              chgCoin  <= greedyCoin(balCoin);
            end else begin
              cancelDone <= 1'b1;
            end
          end else if (bus.sel_valid) begin
            if (idxBad) begin
              errIndex <= 1'b1;
            end else begin
              latIdx  <= bus.sel_index;
              latMode <= bus.pay_mode;
              state   <= CHECK;
              busyR   <= 1'b1;
            end
          end
        end
        CHECK: begin
          // Sufficiency uses the pre-coin funds; a same-cycle coin is netted.
          if (fundsW >= priceW) begin
            if (latMode) credit  <= CRED_W'(credW - priceW);
            else         balance <= BAL_W'(balCoin - priceW);
            state   <= VEND;
            vendReq <= 1'b1;
            vendIdx <= latIdx;
          end else begin
            errFunds <= 1'b1;
            state    <= IDLE;
            busyR    <= 1'b0;
          end
        end
        VEND: begin
          if (bus.vend_ack) begin
            vendReq <= 1'b0;
            state   <= IDLE;
            busyR   <= 1'b0;
          end
        end
        CHANGE: begin
          if (bus.chg_ack) begin
            balance <= BAL_W'(chgRem);
            if (chgRem == {AW{1'b0}}) begin
              chgValid   <= 1'b0;
              cancelDone <= 1'b1;
              state      <= IDLE;
              busyR      <= 1'b0;
            end else begin
              chgCoin <= greedyCoin(chgRem);
            end
          end
        end
        default: begin
          state    <= IDLE;
          busyR    <= 1'b0;
          vendReq  <= 1'b0;
          chgValid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vend_req    = vendReq;
  assign bus.vend_idx    = vendIdx;
  assign bus.chg_valid   = chgValid;
  assign bus.chg_coin    = chgCoin;
  assign bus.balance     = balance;
  assign bus.credit      = credit;
  assign bus.busy        = busyR;
  assign bus.err_funds   = errFunds;
  assign bus.err_index   = errIndex;
  assign bus.coin_reject = coinReject;
  assign bus.cancel_done = cancelDone;
endmodule

// File: tb/tb_vend_payment_ctrl.sv
// Bench for vend_payment_ctrl: directed scenarios with literal expectations
// plus randomized traffic, all checked each cycle against a behavioural model.
module tb_vend_payment_ctrl;
  localparam int NI = 8, PW = 8, BW = 8, CW = 9, IW = 4;
  localparam int BMAX = (1 << BW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vend_payment_ctrl_if #(.NUM_ITEMS(NI), .PRICE_W(PW), .BAL_W(BW), .CRED_W(CW), .IDX_W(IW)) bus();
  vend_payment_ctrl #(.NUM_ITEMS(NI), .PRICE_W(PW), .BAL_W(BW), .CRED_W(CW), .IDX_W(IW))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int cents[4] = '{5, 10, 25, 100};

  // Model: what the customer-visible situation is, not how the RTL encodes it.
  typedef enum {M_IDLE, M_CHECK, M_VEND, M_CHANGE} mphase_t;
  mphase_t mPhase = M_IDLE;
  int  mBal = 0, mCred = 0, mLat = 0;
  bit  mMode = 1'b0;
  int  mPrice[NI];
  bit  eErrFunds, eErrIndex, eCoinReject, eCancelDone;
  int  chgSeq[$];

  function automatic int greedy(input int amt);
    for (int k = 3; k >= 0; k--) if (cents[k] <= amt) return k;
    return 0;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cycle, got, exp);
    end
  endtask

  task automatic modelUpdate();
    int nb, pr, funds;
    bit acc;
    eErrFunds = 0; eErrIndex = 0; eCoinReject = 0; eCancelDone = 0;
    if (rst) begin
      for (int i = 0; i < NI; i++) mPrice[i] = int'(bus.price_table[i*PW +: PW]);
      mCred = int'(bus.cred_init);
      mBal = 0;
      mPhase = M_IDLE;
      return;
    end
    acc = bus.coin_valid && (mPhase != M_CHANGE) && (mBal + cents[bus.coin_type] <= BMAX);
    eCoinReject = bus.coin_valid && !acc;
    nb = mBal + (acc ? cents[bus.coin_type] : 0);
    case (mPhase)
      M_IDLE: begin
        if (bus.cancel) begin
          if (mBal > 0) mPhase = M_CHANGE;
          else eCancelDone = 1;
        end else if (bus.sel_valid) begin
          if (int'(bus.sel_index) >= NI) eErrIndex = 1;
          else begin
            mLat = int'(bus.sel_index);
            mMode = bus.pay_mode;
            mPhase = M_CHECK;
          end
        end
      end
      M_CHECK: begin
        pr = mPrice[mLat];
        funds = mMode ? mCred : mBal;
        if (funds >= pr) begin
          if (mMode) mCred -= pr;
          else nb -= pr;
          mPhase = M_VEND;
        end else begin
          eErrFunds = 1;
          mPhase = M_IDLE;
        end
      end
      M_VEND: if (bus.vend_ack) mPhase = M_IDLE;
      M_CHANGE: begin
        if (bus.chg_ack) begin
          nb -= cents[greedy(mBal)];
          if (nb == 0) begin
            eCancelDone = 1;
            mPhase = M_IDLE;
          end
        end
      end
      default: mPhase = M_IDLE;
    endcase
    mBal = nb;
  endtask

  task automatic compareAll();
    check("balance", int'(bus.balance), mBal);
    check("credit", int'(bus.credit), mCred);
    check("busy", int'(bus.busy), int'(mPhase != M_IDLE));
    check("vend_req", int'(bus.vend_req), int'(mPhase == M_VEND));
    if (mPhase == M_VEND) check("vend_idx", int'(bus.vend_idx), mLat);
    check("chg_valid", int'(bus.chg_valid), int'(mPhase == M_CHANGE));
    if (mPhase == M_CHANGE) check("chg_coin", int'(bus.chg_coin), greedy(mBal));
    check("err_funds", int'(bus.err_funds), int'(eErrFunds));
    check("err_index", int'(bus.err_index), int'(eErrIndex));
    check("coin_reject", int'(bus.coin_reject), int'(eCoinReject));
    check("cancel_done", int'(bus.cancel_done), int'(eCancelDone));
  endtask

  task automatic step();
    @(posedge clk);
    modelUpdate();
    #1;
    compareAll();
    cycle++;
  endtask

  task automatic clearIn();
    bus.coin_valid = 0; bus.coin_type = 0; bus.pay_mode = 0; bus.sel_valid = 0;
    bus.sel_index = 0; bus.cancel = 0; bus.vend_ack = 0; bus.chg_ack = 0;
  endtask

  task automatic coin(input int code);
    bus.coin_valid = 1; bus.coin_type = 2'(code);
    step();
    bus.coin_valid = 0;
  endtask

  task automatic select(input int idx, input bit mode);
    bus.sel_valid = 1; bus.sel_index = 4'(idx); bus.pay_mode = mode;
    step();
    bus.sel_valid = 0;
  endtask

  // Ack every change coin until the controller goes idle (bounded).
  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (!bus.busy) break;
      if (bus.chg_valid) begin
        chgSeq.push_back(int'(bus.chg_coin));
        bus.chg_ack = 1;
      end else bus.chg_ack = 0;
      step();
    end
    bus.chg_ack = 0;
    check("drain_idle", int'(bus.busy), 0);
    check("drain_cancel_done", int'(bus.cancel_done), 1);
  endtask

  task automatic refund();
    chgSeq.delete();
    bus.cancel = 1;
    step();
    bus.cancel = 0;
    drain();
  endtask

  task automatic randomConfig();
    for (int i = 0; i < NI; i++) bus.price_table[i*PW +: PW] = 8'(5 * $urandom_range(1, 51));
    bus.cred_init = 9'(5 * $urandom_range(0, 102));
  endtask

  initial begin
    clearIn();
    // prices: 0:60 1:100 2:65 3:25 4:5 5:150 6:45 7:200
    bus.price_table = {8'd200, 8'd45, 8'd150, 8'd5, 8'd25, 8'd65, 8'd100, 8'd60};
    bus.cred_init = 9'd50;
    rst = 1;
    step(); step();
    rst = 0;
    step();
    check("reset_balance", int'(bus.balance), 0);
    check("reset_credit", int'(bus.credit), 50);
    check("reset_busy", int'(bus.busy), 0);

    // Cash vend of item 2 (65) from 75.
    coin(2); coin(2); coin(2);
    check("cash_bal75", int'(bus.balance), 75);
    select(2, 0);
    check("cash_req_t1", int'(bus.vend_req), 0);
    step();
    check("cash_req_t2", int'(bus.vend_req), 1);
    check("cash_idx", int'(bus.vend_idx), 2);
    check("cash_bal10", int'(bus.balance), 10);
    step(); step(); step();
    check("cash_req_held", int'(bus.vend_req), 1);
    bus.vend_ack = 1; step(); bus.vend_ack = 0;
    check("cash_req_drop", int'(bus.vend_req), 0);
    check("cash_busy_low", int'(bus.busy), 0);
    check("model_bal10", mBal, 10);

    // Refund of 40: 25, 10, 5.
    coin(2); coin(0);
    check("ref_bal40", int'(bus.balance), 40);
    refund();
    check("ref_len", chgSeq.size(), 3);
    if (chgSeq.size() == 3) begin
      check("ref_c0", chgSeq[0], 2);
      check("ref_c1", chgSeq[1], 1);
      check("ref_c2", chgSeq[2], 0);
    end
    check("ref_bal0", int'(bus.balance), 0);

    // Insufficient credit for item 0 (60 > 50).
    select(0, 1);
    step();
    check("cred_err_funds", int'(bus.err_funds), 1);
    check("cred_kept", int'(bus.credit), 50);
    check("cred_no_req", int'(bus.vend_req), 0);
    step();
    check("cred_pulse_end", int'(bus.err_funds), 0);

    // Out-of-range index.
    select(9, 0);
    check("err_index", int'(bus.err_index), 1);
    step();
    check("err_index_end", int'(bus.err_index), 0);

    // Saturation at 255: 200 + 100 dropped.
    coin(3); coin(3); coin(3);
    check("sat_reject", int'(bus.coin_reject), 1);
    check("sat_bal200", int'(bus.balance), 200);
    step();
    check("sat_reject_end", int'(bus.coin_reject), 0);
    refund();

    // Coin during CHECK: 100 + 25 - 100 = 25.
    coin(3);
    select(1, 0);
    bus.coin_valid = 1; bus.coin_type = 2'd2;
    step();
    bus.coin_valid = 0;
    check("net_req", int'(bus.vend_req), 1);
    check("net_bal25", int'(bus.balance), 25);
    bus.vend_ack = 1; step(); bus.vend_ack = 0;

    // Cancel and select together: refund wins.
    bus.cancel = 1; bus.sel_valid = 1; bus.sel_index = 4'd3;
    step();
    bus.cancel = 0; bus.sel_valid = 0;
    check("cs_chg_valid", int'(bus.chg_valid), 1);
    check("cs_chg_coin", int'(bus.chg_coin), 2);
    check("cs_no_req", int'(bus.vend_req), 0);
    drain();

    // Reset in the middle of a refund.
    coin(2); coin(1); coin(0);
    bus.cancel = 1; step(); bus.cancel = 0;
    bus.chg_ack = 1; step();
    check("mid_bal15", int'(bus.balance), 15);
    rst = 1; bus.coin_valid = 1; step();
    rst = 0; bus.chg_ack = 0; bus.coin_valid = 0;
    check("rst_bal", int'(bus.balance), 0);
    check("rst_chg_valid", int'(bus.chg_valid), 0);
    check("rst_credit", int'(bus.credit), 50);
    check("rst_busy", int'(bus.busy), 0);
    bus.cred_init = 9'd77;
    step();
    check("cfg_ignored", int'(bus.credit), 50);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (rst || ($urandom_range(0, 49) == 0)) randomConfig();
      bus.coin_valid = ($urandom_range(0, 9) < 3);
      bus.coin_type  = 2'($urandom_range(0, 3));
      bus.sel_valid  = ($urandom_range(0, 7) == 0);
      bus.sel_index  = 4'($urandom_range(0, 9));
      bus.pay_mode   = 1'($urandom_range(0, 1));
      bus.cancel     = ($urandom_range(0, 19) == 0);
      bus.vend_ack   = ($urandom_range(0, 2) == 0);
      bus.chg_ack    = 1'($urandom_range(0, 1));
      step();
    end
    rst = 0;
    clearIn();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
